aes_encrypt_iter: RTL

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_enc_round.sv | 41 ++++
 rtl/aes_encrypt_iter.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box and Rcon tables, block/schedule types,
// FSM encoding and the byte-level helpers used by the round and key logic.
package aes_pkg;

  typedef logic [127:0]      block_t;
  typedef logic [59:0][31:0] sched_t;

  typedef enum logic {IDLE, ROUND} state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  function automatic int unsigned nr_from_nk(input int unsigned nk);
    return nk + 6;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Full schedule for a key left-aligned in 256 bits; word i sits at index i.
  function automatic sched_t key_schedule(input logic [255:0] key, input int unsigned nk);
    sched_t      w;
    logic [31:0] t;
    w = '0;
    for (int unsigned i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else if (i < 4*(nk + 7)) begin
        t = w[i-1];
        if (i % nk == 0)
          t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i/nk - 1], 24'h000000};
        else if (nk > 6 && i % nk == 4)
          t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; the final round bypasses MixColumns.
module aes_enc_round
  import aes_pkg::*;
(
  input  block_t     state_i,
  input  block_t     round_key_i,
  input  logic       last_round_i,
  output block_t     state_o
);

  block_t      shifted;
  block_t      mixed;
  logic [31:0] col;
  logic [7:0]  a0, a1, a2, a3;

  always_comb begin
    shifted = '0;
    mixed   = '0;
    col     = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    // SubBytes and ShiftRows fused: row r of column c comes from column c+r.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[127 - 32*c - 8*r -: 8] = SBOX[state_i[127 - 32*((c + r) % 4) - 8*r -: 8]];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      col = shifted[127 - 32*c -: 32];
      a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
      if (last_round_i)
        mixed[127 - 32*c -: 32] = col;
      else
        mixed[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    state_o = mixed ^ round_key_i;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: one round per clock, round keys
// expanded combinationally from the key latched at start.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned NK = 8
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NK*32-1:0] key,
  input  logic [127:0]    plaintext,
  output logic            busy,
  output logic            done,
  output logic [127:0]    ciphertext
);

  localparam int unsigned NR     = nr_from_nk(NK);
  localparam logic [3:0]  NR_CNT = 4'(NR);

  state_e           state_q, state_d;
  logic [3:0]       round_q, round_d;
  block_t           blk_q, blk_d;
  logic [NK*32-1:0] key_q, key_d;
  block_t           ct_q, ct_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [255:0] key_pad;
  sched_t       sched;
  logic [5:0]   rk_idx;
  block_t       rk;
  block_t       rnd_out;

  always_comb begin
    key_pad = 256'(key_q) << (256 - NK*32);
    sched   = key_schedule(key_pad, NK);
    rk_idx  = {round_q, 2'b00};
    rk      = {sched[rk_idx], sched[rk_idx + 6'd1], sched[rk_idx + 6'd2], sched[rk_idx + 6'd3]};
  end

  aes_enc_round u_round (
    .state_i      (blk_q),
    .round_key_i  (rk),
    .last_round_i (round_q == NR_CNT),
    .state_o      (rnd_out)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    blk_d   = blk_q;
    key_d   = key_q;
    ct_d    = ct_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Round key 0 is the leading four key words, taken straight from the port.
          key_d   = key;
          blk_d   = plaintext ^ key[NK*32-1 -: 128];
          round_d = 4'd1;
          busy_d  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = rnd_out;
        if (round_q == NR_CNT) begin
          ct_d    = rnd_out;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      blk_q   <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule
